imm_extend_unit: RTL and testbench

// Pipelined immediate generator between decode and the ALU operand mux. It widens
// an IN_W-bit instruction immediate to OUT_W bits. Modes are sign, zero,

---
 rtl/imm_extend_unit_pkg.sv | 8 +
 rtl/imm_extend_core.sv | 26 ++
 rtl/imm_extend_unit.sv | 80 ++++++++
 tb/tb_imm_extend_unit.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/imm_extend_unit_pkg.sv
// imm_extend_unit_pkg: mode encodings shared by the immediate extender and its core
package imm_extend_unit_pkg;
  localparam logic [2:0] MODE_SIGN   = 3'd0;
  localparam logic [2:0] MODE_ZERO   = 3'd1;
  localparam logic [2:0] MODE_SHL1   = 3'd2;
  localparam logic [2:0] MODE_UPPER  = 3'd3;
  localparam logic [2:0] MODE_PREFIX = 3'd4;
endpackage

// File: rtl/imm_extend_core.sv
// imm_extend_core: combinational widening of imm (or {pfx,imm} when pf_pend) per mode; ports mode,pf_pend,pfx,imm -> data,rsv_err
module imm_extend_core
  import imm_extend_unit_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int OUT_W = 16
) (
  input  logic [2:0]       mode,
  input  logic             pf_pend,
  input  logic [IN_W-1:0]  pfx,
  input  logic [IN_W-1:0]  imm,
  output logic [OUT_W-1:0] data,
  output logic             rsv_err
);
  logic [OUT_W-1:0] sext, zext, upper;
  always_comb begin
    sext    = pf_pend ? OUT_W'($signed({pfx, imm})) : OUT_W'($signed(imm));
    zext    = pf_pend ? OUT_W'({pfx, imm}) : OUT_W'(imm);
    upper   = pf_pend ? zext << (OUT_W - 2 * IN_W) : zext << (OUT_W - IN_W);
    rsv_err = mode > MODE_PREFIX;
    data    = mode == MODE_SIGN  ? sext :
              mode == MODE_ZERO  ? zext :
              mode == MODE_SHL1  ? sext << 1 :
              mode == MODE_UPPER ? upper : '0;
  end
endmodule

// File: rtl/imm_extend_unit.sv
// imm_extend_unit: pipelined immediate extender with prefix chaining and 2-entry skid output; ports clk,reset_n,flush,in_valid/in_ready/in_mode/in_imm -> out_valid/out_ready/out_data/out_err
module imm_extend_unit
  import imm_extend_unit_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_mode,
  input  logic [IN_W-1:0]  in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_err
);
  if (IN_W < 2 || OUT_W < 2 * IN_W) begin : g_width_chk
    $error("imm_extend_unit: need IN_W >= 2 and OUT_W >= 2*IN_W");
  end
  logic             pf_pend, err_sticky, skid_v, skid_e, rsv, acc, prod, xfer, is_pfx;
  logic [IN_W-1:0]  pfx;
  logic [OUT_W-1:0] skid_d, new_d;
  imm_extend_core #(.IN_W(IN_W), .OUT_W(OUT_W)) u_core (
    .mode    (in_mode),
    .pf_pend (pf_pend),
    .pfx     (pfx),
    .imm     (in_imm),
    .data    (new_d),
    .rsv_err (rsv)
  );
  assign in_ready = !skid_v;
  always_comb begin
    is_pfx = in_mode == MODE_PREFIX;
    acc    = in_valid & in_ready;
    prod   = acc & !is_pfx;
    xfer   = out_valid & out_ready;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_err    <= 1'b0;
      skid_v     <= 1'b0;
      skid_d     <= '0;
      skid_e     <= 1'b0;
      pfx        <= '0;
      pf_pend    <= 1'b0;
      err_sticky <= 1'b0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_v     <= 1'b0;
      pf_pend    <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      if (acc) begin
        if (is_pfx) pfx <= in_imm;
        pf_pend    <= is_pfx;
        err_sticky <= is_pfx & (err_sticky | pf_pend);
      end
      if (skid_v && xfer) begin
        out_data <= skid_d;
        out_err  <= skid_e;
        skid_v   <= 1'b0;
      end else if (!out_valid || xfer) begin
        out_valid <= prod;
        if (prod) begin
          out_data <= new_d;
          out_err  <= rsv | err_sticky;
        end
      end else if (prod) begin
        skid_v <= 1'b1;
        skid_d <= new_d;
        skid_e <= rsv | err_sticky;
      end
    end
  end
endmodule

// File: tb/tb_imm_extend_unit.sv
// tb_imm_extend_unit: directed and randomized self-checking bench for imm_extend_unit
module tb_imm_extend_unit;
  import imm_extend_unit_pkg::*;
  logic clk = 1'b0;
  logic reset_n, flush, in_valid, in_ready, out_valid, out_ready, out_err;
  logic [2:0] in_mode;
  logic [7:0] in_imm;
  logic [15:0] out_data;
  int checks = 0, errors = 0;
  bit m_pf, m_st;
  int m_pfx;
  logic [16:0] q[$];
  always #5 clk = ~clk;
  imm_extend_unit #(.IN_W(8), .OUT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_mode(in_mode), .in_imm(in_imm), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_err(out_err)
  );
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [2:0] m, input logic [7:0] i);
    in_valid = v;
    in_mode  = m;
    in_imm   = i;
  endtask
  function automatic logic [16:0] ref_result(input int mode, input int imm);
    int rw = m_pf ? 16 : 8;
    longint r = m_pf ? longint'(m_pfx * 256 + imm) : longint'(imm);
    longint s = (r >= (longint'(1) << (rw - 1))) ? r - (longint'(1) << rw) : r;
    longint d;
    if (mode > 4) return {1'b1, 16'h0000};
    d = mode == 0 ? s : mode == 1 ? r : mode == 2 ? s * 2 : r * (longint'(1) << (16 - rw));
    return {m_st, 16'(d & 'hFFFF)};
  endfunction
  task automatic model_accept(input int mode, input int imm);
    if (mode == 4) begin
      m_st  = m_pf;
      m_pf  = 1'b1;
      m_pfx = imm;
    end else begin
      q.push_back(ref_result(mode, imm));
      m_pf = 1'b0;
      m_st = 1'b0;
    end
  endtask
  task automatic apply_reset;
    reset_n = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, MODE_SIGN, 8'h00);
    step;
    step;
    reset_n = 1'b1;
  endtask
  task automatic test_reset;
    apply_reset;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== 16'h0000) begin errors++; $display("FAIL reset_data: got %h want 0000", out_data); end
    checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", out_err); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", in_ready); end
  endtask
  task automatic test_modes;
    logic [2:0]  md[5] = '{MODE_SIGN, MODE_ZERO, MODE_SHL1, MODE_UPPER, 3'd6};
    logic [7:0]  im[5] = '{8'h80, 8'h80, 8'hFE, 8'h12, 8'h55};
    logic [15:0] ed[5] = '{16'hFF80, 16'h0080, 16'hFFFC, 16'h1200, 16'h0000};
    logic        ee[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, md[i], im[i]);
      step;
      checks++; if (out_valid !== 1'b1 || out_data !== ed[i] || out_err !== ee[i])
        begin errors++; $display("FAIL mode%0d: got v=%b d=%h e=%b want v=1 d=%h e=%b", i, out_valid, out_data, out_err, ed[i], ee[i]); end
    end
    drive(1'b0, MODE_SIGN, 8'h00);
    step;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL modes_idle: got v=%b want 0", out_valid); end
  endtask
  task automatic test_prefix;
    logic [7:0]  pf[5] = '{8'h12, 8'h80, 8'hAB, 8'h11, 8'h00};
    logic [7:0]  p2[5] = '{8'h00, 8'h00, 8'h00, 8'h22, 8'h00};
    logic        two[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic        has[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [2:0]  md[5] = '{MODE_SIGN, MODE_SHL1, MODE_UPPER, MODE_ZERO, MODE_SIGN};
    logic [7:0]  im[5] = '{8'h34, 8'h01, 8'hCD, 8'h33, 8'h01};
    logic [15:0] ed[5] = '{16'h1234, 16'h0002, 16'hABCD, 16'h2233, 16'h0001};
    logic        ee[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      if (has[i]) begin
        drive(1'b1, MODE_PREFIX, pf[i]);
        step;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL prefix_noout%0d: got v=%b want 0", i, out_valid); end
      end
      if (two[i]) begin
        drive(1'b1, MODE_PREFIX, p2[i]);
        step;
      end
      drive(1'b1, md[i], im[i]);
      step;
      checks++; if (out_valid !== 1'b1 || out_data !== ed[i] || out_err !== ee[i])
        begin errors++; $display("FAIL prefix%0d: got v=%b d=%h e=%b want v=1 d=%h e=%b", i, out_valid, out_data, out_err, ed[i], ee[i]); end
      drive(1'b0, MODE_SIGN, 8'h00);
      step;
    end
  endtask
  task automatic test_back_to_back_stall;
    out_ready = 1'b0;
    drive(1'b1, MODE_SIGN, 8'h01);
    step;
    checks++; if (out_valid !== 1'b1 || out_data !== 16'h0001 || in_ready !== 1'b1) begin errors++; $display("FAIL stall_first: got v=%b d=%h r=%b want 1 0001 1", out_valid, out_data, in_ready); end
    drive(1'b1, MODE_SIGN, 8'h02);
    step;
    drive(1'b1, MODE_SIGN, 8'h03);
    for (int i = 0; i < 3; i++) begin
      checks++; if (out_valid !== 1'b1 || out_data !== 16'h0001 || in_ready !== 1'b0) begin errors++; $display("FAIL stall_hold%0d: got v=%b d=%h r=%b want 1 0001 0", i, out_valid, out_data, in_ready); end
      step;
    end
    out_ready = 1'b1;
    step;
    checks++; if (out_valid !== 1'b1 || out_data !== 16'h0002 || in_ready !== 1'b1) begin errors++; $display("FAIL stall_second: got v=%b d=%h r=%b want 1 0002 1", out_valid, out_data, in_ready); end
    step;
    checks++; if (out_valid !== 1'b1 || out_data !== 16'h0003) begin errors++; $display("FAIL stall_third: got v=%b d=%h want 1 0003", out_valid, out_data); end
    drive(1'b0, MODE_SIGN, 8'h00);
    step;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_drain: got v=%b want 0", out_valid); end
  endtask
  task automatic test_reset_flush;
    for (int k = 0; k < 2; k++) begin
      out_ready = 1'b0;
      drive(1'b1, MODE_SIGN, 8'h01);
      step;
      drive(1'b1, MODE_PREFIX, 8'h7F);
      step;
      if (k == 0) begin
        drive(1'b0, MODE_SIGN, 8'h00);
        reset_n = 1'b0;
      end else begin
        drive(1'b1, MODE_PREFIX, 8'h66);
        flush = 1'b1;
      end
      step;
      reset_n = 1'b1;
      flush = 1'b0;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL clear%0d: got v=%b r=%b want 0 1", k, out_valid, in_ready); end
      if (k == 0) begin
        checks++; if (out_data !== 16'h0000 || out_err !== 1'b0) begin errors++; $display("FAIL clear_data: got d=%h e=%b want 0000 0", out_data, out_err); end
      end
      out_ready = 1'b1;
      drive(1'b1, MODE_SIGN, 8'h85);
      step;
      checks++; if (out_valid !== 1'b1 || out_data !== 16'hFF85 || out_err !== 1'b0) begin errors++; $display("FAIL after_clear%0d: got v=%b d=%h e=%b want 1 ff85 0", k, out_valid, out_data, out_err); end
      drive(1'b0, MODE_SIGN, 8'h00);
      step;
    end
  endtask
  task automatic test_random;
    int r;
    bit exp_rdy;
    apply_reset;
    m_pf = 1'b0;
    m_st = 1'b0;
    q.delete();
    for (int c = 0; c < 600; c++) begin
      r = $urandom_range(0, 9);
      drive(1'($urandom_range(0, 1)), r < 3 ? MODE_PREFIX : r == 9 ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 3)), 8'($urandom));
      out_ready = $urandom_range(0, 3) != 0;
      flush = $urandom_range(0, 31) == 0;
      exp_rdy = q.size() < 2;
      checks++; if (out_valid !== (q.size() > 0)) begin errors++; $display("FAIL rnd_valid c%0d: got %b want %b", c, out_valid, q.size() > 0); end
      checks++; if (in_ready !== exp_rdy) begin errors++; $display("FAIL rnd_ready c%0d: got %b want %b", c, in_ready, exp_rdy); end
      if (q.size() > 0) begin
        checks++; if ({out_err, out_data} !== q[0]) begin errors++; $display("FAIL rnd_data c%0d: got e=%b d=%h want e=%b d=%h", c, out_err, out_data, q[0][16], q[0][15:0]); end
      end
      if (flush) begin
        q.delete();
        m_pf = 1'b0;
        m_st = 1'b0;
      end else begin
        if (out_ready && q.size() > 0) void'(q.pop_front());
        if (in_valid && exp_rdy) model_accept(int'(in_mode), int'(in_imm));
      end
      step;
    end
    flush = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, MODE_SIGN, 8'h00);
    step;
  endtask
  initial begin
    reset_n = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, MODE_SIGN, 8'h00);
    test_reset;
    test_modes;
    test_prefix;
    test_back_to_back_stall;
    test_reset_flush;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
